// File: rtl/hwpf_stride_pkg.sv
// Shared definitions for the stride-prefetcher request arbiter slice.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package hwpf_stride_pkg;

  localparam int unsigned HWPF_STRIDE_MAX_ENGINES = 16;
  localparam int unsigned HWPF_STRIDE_TID_W       = 8;

  // Default CMO-prefetch request toward the HPDcache. tid is overwritten
  // by the arbiter with the issuing engine index.
  typedef struct packed {
    logic [31:0]                  addr;
    logic [1:0]                   op;
    logic [HWPF_STRIDE_TID_W-1:0] tid;
  } hwpf_cmo_req_t;

  // Default HPDcache response; tid carries the engine index back.
  typedef struct packed {
    logic                         err;
    logic [HWPF_STRIDE_TID_W-1:0] tid;
  } hwpf_cmo_rsp_t;

  // Number of tid bits needed to name an engine; at least one bit so a
  // single-engine build still has a well-formed index.
  function automatic int unsigned hwpf_stride_tid_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hwpf_stride_rr_arb.sv
// Combinational N-input round-robin arbiter; search starts at rr_ptr and wraps.
// Latency: zero (pure combinational); the pointer register lives in the parent.
// Backpressure: enable=0 suppresses every grant; gnt_idx still reports the candidate.
//
// Ports:
//   req     - request vector, one bit per requester
//   rr_ptr  - highest-priority index this cycle (must be < N)
//   enable  - allow a grant this cycle
//   gnt     - one-hot grant (zero when disabled or nothing requests)
//   gnt_idx - binary index of the first requester at/after rr_ptr
//   gnt_vld - a grant is being issued this cycle
module hwpf_stride_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic found;
  int   cand;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    // Walk the requesters in priority order rr_ptr, rr_ptr+1, ... and keep
    // the first one that is asserted.
    for (int off = 0; off < N; off++) begin
      cand = (int'(rr_ptr) + off) % N;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  assign gnt_vld = enable && found;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = gnt_vld && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/hwpf_stride_req_arb.sv
// Merges NUM_HW_PREFETCH stride-engine prefetch streams onto one HPDcache port (round-robin, engine index stamped in tid) and steers responses back by tid.
// Latency: request granted in cycle N appears at the cache in N+1; responses route with zero latency.
// Backpressure: while the output register holds an unaccepted request it stays stable and no engine is granted.
//
// Ports:
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   engine_req_valid_i/_ready_o/_i  - per-engine request handshake and payload (flattened)
//   engine_rsp_valid_o, engine_rsp_o - per-engine response valid, broadcast payload
//   hpdcache_req_valid_o/_ready_i/_o - request port toward the cache
//   hpdcache_rsp_valid_i, hpdcache_rsp_i - response port from the cache
module hwpf_stride_req_arb
  import hwpf_stride_pkg::*;
#(
  parameter int unsigned NUM_HW_PREFETCH = 4,
  parameter type         hpdcache_req_t  = hwpf_cmo_req_t,
  parameter type         hpdcache_rsp_t  = hwpf_cmo_rsp_t
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [NUM_HW_PREFETCH-1:0]                      engine_req_valid_i,
  output logic [NUM_HW_PREFETCH-1:0]                      engine_req_ready_o,
  input  logic [NUM_HW_PREFETCH*$bits(hpdcache_req_t)-1:0] engine_req_i,
  output logic [NUM_HW_PREFETCH-1:0]                      engine_rsp_valid_o,
  output logic [$bits(hpdcache_rsp_t)-1:0]                engine_rsp_o,
  output logic                                            hpdcache_req_valid_o,
  input  logic                                            hpdcache_req_ready_i,
  output logic [$bits(hpdcache_req_t)-1:0]                hpdcache_req_o,
  input  logic                                            hpdcache_rsp_valid_i,
  input  logic [$bits(hpdcache_rsp_t)-1:0]                hpdcache_rsp_i
);

  localparam int unsigned IDX_W = hwpf_stride_tid_w(NUM_HW_PREFETCH);
  localparam int unsigned REQ_W = $bits(hpdcache_req_t);

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  logic                       out_valid_q;
  hpdcache_req_t              out_req_q;
  logic [IDX_W-1:0]           rr_ptr_q;
  logic [IDX_W-1:0]           rr_ptr_nxt;
  logic                       free;
  logic [NUM_HW_PREFETCH-1:0] gnt;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       gnt_vld;
  hpdcache_req_t              win_req;

  // The output register can take a new request when it is empty or its
  // current content is being consumed this very cycle.
  assign free = !out_valid_q || hpdcache_req_ready_i;

  hwpf_stride_rr_arb #(
    .N     (int'(NUM_HW_PREFETCH)),
    .IDX_W (int'(IDX_W))
  ) u_rr_arb (
    .req     (engine_req_valid_i),
    .rr_ptr  (rr_ptr_q),
    .enable  (free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign engine_req_ready_o = gnt;

  // Winner payload with its tid replaced by the zero-extended engine index;
  // whatever the engine put in tid is discarded.
  always_comb begin
    win_req                = hpdcache_req_t'(engine_req_i[int'(gnt_idx)*REQ_W +: REQ_W]);
    win_req.tid            = '0;
    win_req.tid[IDX_W-1:0] = gnt_idx;
  end

  // Pointer moves just past the winner, wrapping at the last engine.
  assign rr_ptr_nxt = (32'(gnt_idx) + 32'd1 >= NUM_HW_PREFETCH) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (free) begin
      if (gnt_vld) begin
        out_valid_q <= 1'b1;
        out_req_q   <= win_req;
        rr_ptr_q    <= rr_ptr_nxt;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign hpdcache_req_valid_o = out_valid_q;
  assign hpdcache_req_o       = out_req_q;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  hpdcache_rsp_t    rsp;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_hit;

  assign rsp = hpdcache_rsp_t'(hpdcache_rsp_i);

  // A tid that names no existing engine (index out of range or stray upper
  // bits) is dropped rather than aliased onto a real engine.
  always_comb begin
    rsp_idx = rsp.tid[IDX_W-1:0];
    rsp_hit = ((rsp.tid >> IDX_W) == '0) && (32'(rsp_idx) < NUM_HW_PREFETCH);
    engine_rsp_valid_o = '0;
    for (int i = 0; i < int'(NUM_HW_PREFETCH); i++) begin
      engine_rsp_valid_o[i] = hpdcache_rsp_valid_i && rsp_hit && (rsp_idx == IDX_W'(i));
    end
  end

  assign engine_rsp_o = rsp;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (hpdcache_req_valid_o && !hpdcache_req_ready_i) |=> $stable(hpdcache_req_o));

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(engine_req_ready_o));

endmodule

// File: tb/tb_hwpf_stride_req_arb.sv
module tb_hwpf_stride_req_arb;
  import hwpf_stride_pkg::*;

  localparam int N     = 4;
  localparam int REQ_W = $bits(hwpf_cmo_req_t);
  localparam int RSP_W = $bits(hwpf_cmo_rsp_t);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     eng_valid;
  logic [N-1:0]     eng_ready;
  logic [N*REQ_W-1:0] eng_req;
  logic [N-1:0]     eng_rsp_valid;
  logic [RSP_W-1:0] eng_rsp;
  logic             c_req_valid;
  logic             c_req_ready;
  logic [REQ_W-1:0] c_req;
  logic             c_rsp_valid;
  logic [RSP_W-1:0] c_rsp;

  always #5 clk = ~clk;

  hwpf_stride_req_arb #(.NUM_HW_PREFETCH(N)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .engine_req_valid_i   (eng_valid),
    .engine_req_ready_o   (eng_ready),
    .engine_req_i         (eng_req),
    .engine_rsp_valid_o   (eng_rsp_valid),
    .engine_rsp_o         (eng_rsp),
    .hpdcache_req_valid_o (c_req_valid),
    .hpdcache_req_ready_i (c_req_ready),
    .hpdcache_req_o       (c_req),
    .hpdcache_rsp_valid_i (c_rsp_valid),
    .hpdcache_rsp_i       (c_rsp)
  );

  typedef struct packed {
    logic [N-1:0]  vld;
    hwpf_cmo_rsp_t rsp;
  } rsp_exp_t;

  int vectors     = 0;
  int miscompares = 0;
  hwpf_cmo_req_t exp_req_q[$];
  rsp_exp_t      exp_rsp_q[$];

  // Engine e always offers addr A000_0000 + 0x40*e, op=e[1:0], and a junk tid.
  function automatic hwpf_cmo_req_t eng_payload(input int e);
    hwpf_cmo_req_t r;
    r.addr = 32'hA000_0000 + 32'(e) * 32'h40;
    r.op   = 2'(e);
    r.tid  = 8'hC0 + 8'(e);
    return r;
  endfunction

  // What the cache must see for engine e: same payload, tid = e.
  function automatic hwpf_cmo_req_t cache_req(input int e);
    hwpf_cmo_req_t r;
    r.addr = 32'hA000_0000 + 32'(e) * 32'h40;
    r.op   = 2'(e);
    r.tid  = 8'(e);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rsp(input logic [7:0] tid, input logic err, input logic [N-1:0] exp_vld);
    rsp_exp_t x;
    hwpf_cmo_rsp_t r;
    r.err = err;
    r.tid = tid;
    c_rsp_valid = 1'b1;
    c_rsp       = r;
    x.vld = exp_vld;
    x.rsp = r;
    exp_rsp_q.push_back(x);
  endtask

  // Monitor: every accepted cache request and every presented response is
  // matched against the next expected entry.
  always @(negedge clk) begin
    if (!rst && c_req_valid && c_req_ready) begin
      if (exp_req_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL req_unexpected: got %h expected no request at %0t", c_req, $time);
      end else begin
        hwpf_cmo_req_t e;
        e = exp_req_q.pop_front();
        check("req_xfer", 64'(c_req), 64'(e));
      end
    end
    if (c_rsp_valid) begin
      if (exp_rsp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got %h expected no response at %0t", c_rsp, $time);
      end else begin
        rsp_exp_t x;
        x = exp_rsp_q.pop_front();
        check("rsp_valid", 64'(eng_rsp_valid), 64'(x.vld));
        check("rsp_data", 64'(eng_rsp), 64'(x.rsp));
      end
    end
  end

  logic [N-1:0] rot_tbl [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int           rot_eng [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst         = 1'b1;
    eng_valid   = '0;
    c_req_ready = 1'b0;
    c_rsp_valid = 1'b0;
    c_rsp       = '0;
    for (int e = 0; e < N; e++) eng_req[e*REQ_W +: REQ_W] = eng_payload(e);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_valid", 64'(c_req_valid), 64'd0);
    check("reset_data", 64'(c_req), 64'd0);
    check("reset_ready", 64'(eng_ready), 64'd0);
    tick();
    rst = 1'b0;
    c_req_ready = 1'b1;

    // Idle for 10 cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_valid", 64'(c_req_valid), 64'd0);
      check("idle_ready", 64'(eng_ready), 64'd0);
      tick();
    end

    // All engines valid, ready high: strict rotation
    eng_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(eng_ready), 64'(rot_tbl[k]));
      exp_req_q.push_back(cache_req(rot_eng[k]));
      tick();
    end
    eng_valid = '0;
    tick();
    tick();

    // Engine 2 alone under backpressure
    eng_valid   = 4'b0100;
    c_req_ready = 1'b0;
    @(negedge clk);
    check("bp_first_grant", 64'(eng_ready), 64'b0100);
    exp_req_q.push_back(cache_req(2));
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("bp_no_grant", 64'(eng_ready), 64'd0);
      check("bp_valid", 64'(c_req_valid), 64'd1);
      check("bp_hold", 64'(c_req), 64'(cache_req(2)));
    end
    tick();
    c_req_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 64'(eng_ready), 64'b0100);
    exp_req_q.push_back(cache_req(2));
    tick();
    eng_valid = '0;
    tick();
    tick();

    // Pointer sits at 3: engines 0 and 3 valid -> 3 first, then 0
    eng_valid = 4'b1001;
    @(negedge clk);
    check("wrap_grant_3", 64'(eng_ready), 64'b1000);
    exp_req_q.push_back(cache_req(3));
    tick();
    @(negedge clk);
    check("wrap_grant_0", 64'(eng_ready), 64'b0001);
    exp_req_q.push_back(cache_req(0));
    tick();
    eng_valid = '0;
    tick();

    // Responses, the first one concurrent with a grant to the same engine
    eng_valid = 4'b0010;
    send_rsp(8'd1, 1'b0, 4'b0010);
    @(negedge clk);
    check("rsp_concurrent_grant", 64'(eng_ready), 64'b0010);
    exp_req_q.push_back(cache_req(1));
    tick();
    eng_valid = '0;
    send_rsp(8'd3, 1'b1, 4'b1000);
    tick();
    send_rsp(8'd7, 1'b0, 4'b0000);
    tick();
    send_rsp(8'h11, 1'b1, 4'b0000);
    tick();
    send_rsp(8'd0, 1'b0, 4'b0001);
    tick();
    c_rsp_valid = 1'b0;
    c_rsp       = 9'h002;
    @(negedge clk);
    check("rsp_idle", 64'(eng_rsp_valid), 64'd0);
    tick();

    // Reset while a request is stuck in the output register
    eng_valid   = 4'b0100;
    c_req_ready = 1'b0;
    @(negedge clk);
    check("rst_pre_grant", 64'(eng_ready), 64'b0100);
    tick();
    eng_valid = '0;
    @(negedge clk);
    check("rst_pre_valid", 64'(c_req_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    eng_valid   = 4'b1100;
    c_req_ready = 1'b1;
    @(negedge clk);
    check("rst_drop_valid", 64'(c_req_valid), 64'd0);
    check("rst_drop_data", 64'(c_req), 64'd0);
    check("rst_first_grant", 64'(eng_ready), 64'b0100);
    exp_req_q.push_back(cache_req(2));
    tick();
    eng_valid = '0;
    repeat (4) tick();

    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
